// File: rtl/multicore_pkg.sv
// Shared types and defaults for the core's memory-side blocks.
// The data cache uses the FSM state type, the default line count and
// the byte-merge helper from this package.
package multicore_pkg;

  localparam int DCACHE_NUM_LINES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } dcache_state_t;

  // Returns old_word with the bytes selected by be replaced from new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Two asynchronous read ports: rd_* is indexed by the live request address,
// chk_* by the registered in-flight address (store hit check at ack time).
// Writes are synchronous: a full-line install or a byte-merge into data.
// flush clears every valid bit in one cycle and suppresses any same-cycle
// install or merge, so a flushed cycle never leaves a line behind.
module dcache_array
  import multicore_pkg::*;
#(
  parameter int  NUM_LINES = DCACHE_NUM_LINES,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] chk_idx,
  output logic             chk_valid,
  output logic [TAG_W-1:0] chk_tag,
  input  logic             install,
  input  logic             merge,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             flush
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_data   = data_q[rd_idx];
  assign chk_valid = valid_q[chk_idx];
  assign chk_tag   = tag_q[chk_idx];

  // Valid bits: reset and flush clear all, install sets one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (install) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (install) begin
        tag_q[wr_idx]  <= wr_tag;
        data_q[wr_idx] <= wr_data;
      end else if (merge) begin
        data_q[wr_idx] <= merge_bytes(data_q[wr_idx], wr_data, wr_be);
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MA stage.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
//
// Handshakes:
//   MA side  - i_req marks an access; it completes in the cycle o_ready=1
//              (load hits in the request cycle, everything else in RESP).
//              o_rdata is valid while o_ready & ~i_we.
//   Mem side - o_mem_req and its fields are registered and held stable until
//              the single-cycle i_mem_ack; read data is sampled with the ack.
//              An ack while no transaction is outstanding is ignored.
module dcache_ctrl
  import multicore_pkg::*;
#(
  parameter int NUM_LINES = DCACHE_NUM_LINES
) (
  input  logic          i_aclk,
  input  logic          i_areset,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_flush,
  output logic          o_ready,
  output logic [31:0]   o_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [31:0]   o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [31:0]   i_mem_rdata,
  output dcache_state_t o_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   o_hit_count,
  output logic [31:0]   o_miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  dcache_state_t state;
  logic [31:0]   resp_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;

  logic [IDX_W-1:0] fl_idx;
  logic [TAG_W-1:0] fl_tag;
  logic             chk_valid;
  logic [TAG_W-1:0] chk_tag;
  logic             fl_hit;

  logic             install;
  logic             merge;
  logic [31:0]      wr_data;

  // Word-offset bits of the byte address carry no information for a word cache.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = i_addr[1:0];

  assign req_idx = i_addr[2 +: IDX_W];
  assign req_tag = i_addr[31 -: TAG_W];
  assign hit     = rd_valid && (rd_tag == req_tag);

  // The in-flight address lives in o_mem_addr, so it doubles as the
  // index/tag for install, merge and the store hit check.
  assign fl_idx  = o_mem_addr[2 +: IDX_W];
  assign fl_tag  = o_mem_addr[31 -: TAG_W];
  assign fl_hit  = chk_valid && (chk_tag == fl_tag);

  assign install = (state == RD_MISS) && i_mem_ack;
  assign merge   = (state == WR_THRU) && i_mem_ack && fl_hit;
  assign wr_data = (state == RD_MISS) ? i_mem_rdata : o_mem_wdata;

  assign o_state = state;

  dcache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk       (i_aclk),
    .rst       (i_areset),
    .rd_idx    (req_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .chk_idx   (fl_idx),
    .chk_valid (chk_valid),
    .chk_tag   (chk_tag),
    .install   (install),
    .merge     (merge),
    .wr_idx    (fl_idx),
    .wr_tag    (fl_tag),
    .wr_data   (wr_data),
    .wr_be     (o_mem_be),
    .flush     (i_flush)
  );

  // MA-side response: combinational from state, array contents and i_addr.
  always_comb begin
    o_ready = 1'b0;
    o_rdata = '0;
    case (state)
      IDLE: begin
        o_ready = !i_req || (!i_we && hit);
        o_rdata = hit ? rd_data : 32'h0;
      end
      RESP: begin
        o_ready = 1'b1;
        o_rdata = resp_q;
      end
      default: begin
        o_ready = 1'b0;
        o_rdata = '0;
      end
    endcase
  end

  // Controller FSM with registered memory-bus outputs and response register.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state       <= IDLE;
      resp_q      <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            if (i_we) begin
              state       <= WR_THRU;
              o_mem_req   <= 1'b1;
              o_mem_we    <= 1'b1;
              o_mem_be    <= i_be;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_wdata <= i_wdata;
            end else if (!hit) begin
              state       <= RD_MISS;
              o_mem_req   <= 1'b1;
              o_mem_we    <= 1'b0;
              o_mem_be    <= 4'hF;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_wdata <= '0;
            end
          end
        end
        RD_MISS: begin
          if (i_mem_ack) begin
            resp_q    <= i_mem_rdata;
            o_mem_req <= 1'b0;
            state     <= RESP;
          end
        end
        WR_THRU: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic store_hit_q;

  // Access statistics: one count per completed access; flush leaves them alone.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
      store_hit_q  <= 1'b0;
    end else begin
      if (state == IDLE && i_req && !i_we && hit) begin
        o_hit_count <= o_hit_count + 32'd1;
      end
      if (state == RD_MISS && i_mem_ack) begin
        store_hit_q <= 1'b0;
      end
      if (state == WR_THRU && i_mem_ack) begin
        store_hit_q <= fl_hit;
      end
      if (state == RESP) begin
        if (store_hit_q) o_hit_count  <= o_hit_count + 32'd1;
        else             o_miss_count <= o_miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// accesses, checked against a line-level cache model and a word memory model.
module tb_dcache_ctrl;
  import multicore_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req = 0, i_we = 0, i_flush = 0, i_mem_ack = 0;
  logic [3:0]    i_be = 0;
  logic [31:0]   i_addr = 0, i_wdata = 0, i_mem_rdata = 0;
  logic          o_ready, o_mem_req, o_mem_we;
  logic [31:0]   o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]    o_mem_be;
  dcache_state_t o_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]   o_hit_count, o_miss_count;
  int unsigned   m_hits = 0, m_misses = 0;
`endif

  dcache_ctrl dut (
    .i_aclk      (clk),
    .i_areset    (rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_be        (i_be),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_flush     (i_flush),
    .o_ready     (o_ready),
    .o_rdata     (o_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_state     (o_state)
`ifdef DCACHE_STATS_EN
    ,
    .o_hit_count (o_hit_count),
    .o_miss_count(o_miss_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // 16 one-word lines; index = word address mod 16, tag = word address / 16.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem [int unsigned];

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == (a >> 6));
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (!mem.exists(a >> 2)) mem[a >> 2] = $urandom;
    return mem[a >> 2];
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  // One complete MA access. hit_o: o_ready seen in the request cycle.
  // rd_o: load data returned (hit cycle or RESP).
  task automatic access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input bit flush_ack,
                        output bit hit_o, output logic [31:0] rd_o);
    bit          exp_hit;
    logic [31:0] ack_data, old_word, new_word;
    int          ln;
    ln = line_of(addr);
    rd_o = '0;
    @(posedge clk); #1;
    i_req = 1; i_we = we; i_be = be; i_addr = addr; i_wdata = wdata;
    exp_hit = model_hit(addr);
    @(negedge clk);
    hit_o = o_ready;
    if (!we && exp_hit) begin
      exp_q.push_back(m_data[ln]);
      check("hit_ready", {31'b0, o_ready}, 32'd1);
      rd_o = o_rdata;
      check("hit_rdata", o_rdata, exp_q.pop_front());
`ifdef DCACHE_STATS_EN
      m_hits++;
`endif
      @(posedge clk); #1;
      i_req = 0;
      return;
    end
    check("req_ready", {31'b0, o_ready}, 32'd0);
    @(posedge clk); #1;
    // Disturb the MA-side inputs: the memory request must not follow them.
    i_req = 0; i_addr = $urandom; i_we = 1'($urandom); i_be = 4'($urandom); i_wdata = $urandom;
    ack_data = '0;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      check("mem_req", {31'b0, o_mem_req}, 32'd1);
      check("mem_we", {31'b0, o_mem_we}, {31'b0, we});
      check("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
      check("mem_be", {28'b0, o_mem_be}, {28'b0, (we ? be : 4'hF)});
      if (we) check("mem_wdata", o_mem_wdata, wdata);
      check("stall_ready", {31'b0, o_ready}, 32'd0);
      if (k == waits) begin
        ack_data    = we ? $urandom : mem_read(addr);
        i_mem_ack   = 1;
        i_mem_rdata = ack_data;
        i_flush     = flush_ack;
      end
    end
    @(posedge clk); #1;
    i_mem_ack = 0; i_flush = 0; i_mem_rdata = $urandom;
    // model update at ack
    if (!we) begin
      exp_q.push_back(ack_data);
      if (!flush_ack) begin
        m_valid[ln] = 1'b1;
        m_tag[ln]   = addr >> 6;
        m_data[ln]  = ack_data;
      end
`ifdef DCACHE_STATS_EN
      m_misses++;
`endif
    end else begin
      old_word = mem_read(addr);
      new_word = old_word;
      for (int b = 0; b < 4; b++) if (be[b]) new_word[8*b +: 8] = wdata[8*b +: 8];
      mem[addr >> 2] = new_word;
      if (exp_hit && !flush_ack) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_data[ln][8*b +: 8] = wdata[8*b +: 8];
      end
`ifdef DCACHE_STATS_EN
      if (exp_hit) m_hits++; else m_misses++;
`endif
    end
    if (flush_ack) model_flush();
    @(negedge clk);
    check("resp_ready", {31'b0, o_ready}, 32'd1);
    check("resp_req_drop", {31'b0, o_mem_req}, 32'd0);
    if (!we) begin
      rd_o = o_rdata;
      check("resp_rdata", o_rdata, exp_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_flush();
    @(posedge clk); #1;
    i_flush = 1;
    @(negedge clk);
    check("flush_idle_ready", {31'b0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_flush = 0;
    model_flush();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_mreq"}, {31'b0, o_mem_req}, 32'd0);
    check({tag, "_mwe"}, {31'b0, o_mem_we}, 32'd0);
    check({tag, "_mbe"}, {28'b0, o_mem_be}, 32'd0);
    check({tag, "_maddr"}, o_mem_addr, 32'd0);
    check({tag, "_mwdata"}, o_mem_wdata, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  bit          h;
  logic [31:0] rd;
  logic [31:0] tag_pool [4];

  initial begin
    tag_pool[0] = 32'h0; tag_pool[1] = 32'h1; tag_pool[2] = 32'h3FF_FFFF; tag_pool[3] = 32'h200_0005;
    model_flush();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // cold miss, 2 wait cycles, then same-cycle hit
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    access(0, 4'h0, 32'h100, 0, 2, 0, h, rd);
    check("cold_miss", {31'b0, h}, 32'd0);
    check("cold_data", rd, 32'hDEADBEEF);
    access(0, 4'h0, 32'h100, 0, 0, 0, h, rd);
    check("reload_hit", {31'b0, h}, 32'd1);
    check("reload_data", rd, 32'hDEADBEEF);

    // partial store hit with 3 wait cycles, then merged hit
    access(1, 4'b0011, 32'h100, 32'h0000CAFE, 3, 0, h, rd);
    access(0, 4'h0, 32'h100, 0, 0, 0, h, rd);
    check("merge_hit", {31'b0, h}, 32'd1);
    check("merge_data", rd, 32'hDEADCAFE);

    // store miss does not allocate
    access(1, 4'hF, 32'h200, 32'h01020304, 0, 0, h, rd);
    access(0, 4'h0, 32'h200, 0, 1, 0, h, rd);
    check("no_alloc_miss", {31'b0, h}, 32'd0);
    check("no_alloc_data", rd, 32'h01020304);

    // conflict eviction on index 0
    access(0, 4'h0, 32'h100, 0, 0, 0, h, rd);
    check("evict_a_miss", {31'b0, h}, 32'd0);
    access(0, 4'h0, 32'h140, 0, 0, 0, h, rd);
    check("evict_b_miss", {31'b0, h}, 32'd0);
    access(0, 4'h0, 32'h100, 0, 0, 0, h, rd);
    check("evict_reload_miss", {31'b0, h}, 32'd0);

    // flush on the RD_MISS ack cycle
    mem[32'h180 >> 2] = 32'h12345678;
    access(0, 4'h0, 32'h180, 0, 1, 1, h, rd);
    check("flush_ack_data", rd, 32'h12345678);
    access(0, 4'h0, 32'h180, 0, 0, 0, h, rd);
    check("flush_ack_next_miss", {31'b0, h}, 32'd0);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = {tag_pool[$urandom_range(0, 3)][25:0], 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 19) == 0) idle_flush();
      access(($urandom_range(0, 3) == 0), 4'($urandom), a, $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 15) == 0), h, rd);
    end

`ifdef DCACHE_STATS_EN
    check("stat_hits", o_hit_count, m_hits);
    check("stat_misses", o_miss_count, m_misses);
`endif

    // reset while in WR_THRU
    @(posedge clk); #1;
    i_req = 1; i_we = 1; i_be = 4'hF; i_addr = 32'h300; i_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    i_req = 0; i_we = 0;
    @(negedge clk);
    check("wr_thru_req", {31'b0, o_mem_req}, 32'd1);
    rst = 1;
    #1;
    check("rst_async_req", {31'b0, o_mem_req}, 32'd0);
    model_flush();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    i_mem_ack = 1; i_mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    i_mem_ack = 0;
    @(negedge clk);
    i_addr = 0;
    #1;
    check_reset_outputs("late_ack");
`ifdef DCACHE_STATS_EN
    check("stat_rst_hits", o_hit_count, 32'd0);
    check("stat_rst_misses", o_miss_count, 32'd0);
`endif
    access(0, 4'h0, 32'h100, 0, 0, 0, h, rd);
    check("post_rst_miss", {31'b0, h}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
